// File: rtl/pkt_len_meter_pkg.sv
// Shared types and constants for the packet length meter.
package pkt_meter_pkg;

  // Framing state: no packet open, or a packet open and accumulating.
  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_e;

  // Why a finalized packet did not produce a record.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ERR   = 2'd1,
    RUNT  = 2'd2,
    GIANT = 2'd3
  } drop_e;

  // Ceiling for the event counters.
  localparam logic [15:0] SAT16 = 16'hFFFF;

  // Ceiling for the length accumulator; any value here is a giant.
  localparam logic [16:0] LEN_SAT = 17'h1FFFF;

endpackage

// File: rtl/pkt_len_meter_sat_counter.sv
// 16-bit saturating event counter. inc_i is the amount to add this cycle
// (0..2), because abort can be bumped twice in one cycle.
module sat_counter
  import pkt_meter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  inc_i,
  output logic [15:0] cnt_o
);

  logic [16:0] sum;

  assign sum = {1'b0, cnt_o} + {15'd0, inc_i};

  // Add the increment, clamping at the ceiling instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                   cnt_o <= '0;
    else if (sum > {1'b0, SAT16}) cnt_o <= SAT16;
    else                          cnt_o <= sum[15:0];
  end

endmodule

// File: rtl/pkt_len_meter.sv
// Packet length meter: measures each framed packet, drops runts, giants,
// aborted and errored packets, and emits one {flow, size} strobe per good
// packet one cycle after its eop beat.
//
// Stream semantics: a beat is transferred on every cycle st_valid_i is high;
// there is no ready, so the meter must accept every valid beat. st_flow_i is
// meaningful on sop beats, st_empty_i and st_err_i on eop beats only.
module pkt_len_meter
  import pkt_meter_pkg::*;
#(
  parameter int A_WIDTH    = 10,
  parameter int DATA_BYTES = 8,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 9600
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          st_valid_i,
  input  logic                          st_sop_i,
  input  logic                          st_eop_i,
  input  logic [$clog2(DATA_BYTES)-1:0] st_empty_i,
  input  logic [A_WIDTH-1:0]            st_flow_i,
  input  logic                          st_err_i,
  output logic [A_WIDTH-1:0]            rx_flow_num_o,
  output logic [15:0]                   pkt_size_o,
  output logic                          pkt_size_en_o,
  output logic [15:0]                   runt_cnt_o,
  output logic [15:0]                   giant_cnt_o,
  output logic [15:0]                   abort_cnt_o
);

  localparam logic [17:0] DB18    = 18'(DATA_BYTES);
  localparam logic [16:0] DB17    = 17'(DATA_BYTES);
  localparam logic [16:0] MIN_L17 = 17'(MIN_LEN);
  localparam logic [16:0] MAX_L17 = 17'(MAX_LEN);

  // FSM state is a named signal so checkers can bind to it directly.
  state_e               state;
  logic [16:0]          len_q;
  logic [A_WIDTH-1:0]   flow_q;

  logic                 orphan;
  logic                 sop_abort;
  logic                 fin;
  logic [16:0]          fin_base;
  logic [A_WIDTH-1:0]   fin_flow;
  logic [17:0]          fin_sum;
  logic [16:0]          fin_len;
  logic [17:0]          acc_sum;
  logic [16:0]          acc_len;
  drop_e                reason;
  logic [1:0]           runt_inc;
  logic [1:0]           giant_inc;
  logic [1:0]           abort_inc;

  function automatic drop_e classify(input logic [16:0] l, input logic err);
    if (err)               return ERR;
    else if (l < MIN_L17)  return RUNT;
    else if (l > MAX_L17)  return GIANT;
    else                   return NONE;
  endfunction

  // Decode the current beat: abort/orphan detection, final length and verdict.
  always_comb begin
    orphan    = st_valid_i & ~st_sop_i & (state == IDLE);
    sop_abort = st_valid_i &  st_sop_i & (state == IN_PKT);
    fin       = st_valid_i &  st_eop_i & (st_sop_i | (state == IN_PKT));
    // A sop beat starts a fresh packet, so its length base is zero.
    fin_base  = st_sop_i ? 17'd0 : len_q;
    fin_flow  = st_sop_i ? st_flow_i : flow_q;
    // empty is always below DATA_BYTES, so this cannot underflow.
    fin_sum   = {1'b0, fin_base} + DB18 - 18'(st_empty_i);
    fin_len   = fin_sum[17] ? LEN_SAT : fin_sum[16:0];
    acc_sum   = {1'b0, len_q} + DB18;
    acc_len   = acc_sum[17] ? LEN_SAT : acc_sum[16:0];
    reason    = fin ? classify(fin_len, st_err_i) : NONE;
    runt_inc  = {1'b0, reason == RUNT};
    giant_inc = {1'b0, reason == GIANT};
    abort_inc = 2'({1'b0, sop_abort}) + 2'({1'b0, orphan}) +
                2'({1'b0, reason == ERR});
  end

  // Framing FSM, length accumulator and registered record outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      len_q         <= '0;
      flow_q        <= '0;
      pkt_size_en_o <= 1'b0;
      rx_flow_num_o <= '0;
      pkt_size_o    <= '0;
    end else begin
      pkt_size_en_o <= 1'b0;
      if (st_valid_i) begin
        if (st_sop_i) begin
          flow_q <= st_flow_i;
          if (st_eop_i) begin
            state <= IDLE;
            len_q <= '0;
          end else begin
            state <= IN_PKT;
            len_q <= DB17;
          end
        end else if (state == IN_PKT) begin
          if (st_eop_i) begin
            state <= IDLE;
            len_q <= '0;
          end else begin
            len_q <= acc_len;
          end
        end
      end
      if (fin && (reason == NONE)) begin
        pkt_size_en_o <= 1'b1;
        rx_flow_num_o <= fin_flow;
        pkt_size_o    <= fin_len[15:0];
      end
    end
  end

  sat_counter u_runt_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (runt_inc),
    .cnt_o (runt_cnt_o)
  );

  sat_counter u_giant_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (giant_inc),
    .cnt_o (giant_cnt_o)
  );

  sat_counter u_abort_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (abort_inc),
    .cnt_o (abort_cnt_o)
  );

endmodule

// File: tb/tb_pkt_len_meter.sv
// Directed bench for pkt_len_meter: records are captured by a monitor and
// matched against an expected queue; counters are checked after each step.
module tb_pkt_len_meter;

  localparam int A_WIDTH    = 10;
  localparam int DATA_BYTES = 8;
  localparam int EW         = $clog2(DATA_BYTES);
  localparam int RW         = A_WIDTH + 16;

  logic               clk_i;
  logic               rst_i;
  logic               st_valid_i;
  logic               st_sop_i;
  logic               st_eop_i;
  logic [EW-1:0]      st_empty_i;
  logic [A_WIDTH-1:0] st_flow_i;
  logic               st_err_i;
  logic [A_WIDTH-1:0] rx_flow_num_o;
  logic [15:0]        pkt_size_o;
  logic               pkt_size_en_o;
  logic [15:0]        runt_cnt_o;
  logic [15:0]        giant_cnt_o;
  logic [15:0]        abort_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];

  pkt_len_meter #(
    .A_WIDTH    (A_WIDTH),
    .DATA_BYTES (DATA_BYTES),
    .MIN_LEN    (64),
    .MAX_LEN    (9600)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .st_valid_i    (st_valid_i),
    .st_sop_i      (st_sop_i),
    .st_eop_i      (st_eop_i),
    .st_empty_i    (st_empty_i),
    .st_flow_i     (st_flow_i),
    .st_err_i      (st_err_i),
    .rx_flow_num_o (rx_flow_num_o),
    .pkt_size_o    (pkt_size_o),
    .pkt_size_en_o (pkt_size_en_o),
    .runt_cnt_o    (runt_cnt_o),
    .giant_cnt_o   (giant_cnt_o),
    .abort_cnt_o   (abort_cnt_o)
  );

  // Clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Monitor: capture every record strobe just after the active edge.
  always @(posedge clk_i) begin
    #1;
    if (pkt_size_en_o === 1'b1) got_q.push_back({rx_flow_num_o, pkt_size_o});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare captured records with the expected queue, then clear both.
  task automatic chk_records(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [RW-1:0] g;
      logic [RW-1:0] e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_flow"}, 32'(g[RW-1:16]), 32'(e[RW-1:16]));
      chk({tag, "_size"}, 32'(g[15:0]), 32'(e[15:0]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [EW-1:0] emp, input logic [A_WIDTH-1:0] fl,
                       input logic err);
    @(negedge clk_i);
    st_valid_i = v;
    st_sop_i   = s;
    st_eop_i   = e;
    st_empty_i = emp;
    st_flow_i  = fl;
    st_err_i   = err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // One packet of nb beats; optional sop/eop framing and random idle gaps.
  task automatic send_pkt(input logic [A_WIDTH-1:0] fl, input int nb,
                          input logic [EW-1:0] emp, input logic err,
                          input logic with_sop, input logic with_eop,
                          input logic gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps && i > 0) idle($urandom_range(0, 2));
      drive(1'b1, with_sop && (i == 0), with_eop && (i == nb - 1),
            emp, fl, err && (i == nb - 1));
    end
  endtask

  initial begin
    rst_i      = 1'b0;
    st_valid_i = 1'b0;
    st_sop_i   = 1'b0;
    st_eop_i   = 1'b0;
    st_empty_i = '0;
    st_flow_i  = '0;
    st_err_i   = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset values
    chk("rst_en",    32'(pkt_size_en_o), 0);
    chk("rst_flow",  32'(rx_flow_num_o), 0);
    chk("rst_size",  32'(pkt_size_o), 0);
    chk("rst_runt",  32'(runt_cnt_o), 0);
    chk("rst_giant", 32'(giant_cnt_o), 0);
    chk("rst_abort", 32'(abort_cnt_o), 0);
    rst_i = 1'b1;
    idle(2);

    // Exactly MIN_LEN: flow 5, 8 beats -> 64 bytes
    send_pkt(10'd5, 8, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({10'd5, 16'd64});
    idle(2);
    chk_records("min_len");
    chk("min_runt",  32'(runt_cnt_o), 0);
    chk("min_giant", 32'(giant_cnt_o), 0);
    chk("min_abort", 32'(abort_cnt_o), 0);

    // Runt: 3 beats, empty 4 -> 20 bytes
    send_pkt(10'd3, 3, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk_records("runt");
    chk("runt_cnt", 32'(runt_cnt_o), 1);

    // Abort by new sop: flow 7 open, then flow 9, 9 beats, empty 2 -> 70
    send_pkt(10'd7, 3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_pkt(10'd9, 9, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({10'd9, 16'd70});
    idle(2);
    chk_records("sop_abort");
    chk("sop_abort_cnt", 32'(abort_cnt_o), 1);
    chk("sop_abort_runt", 32'(runt_cnt_o), 1);

    // Giant: 1201 beats -> 9608; then exactly MAX_LEN: 1200 beats -> 9600
    send_pkt(10'd1, 1201, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk_records("giant");
    chk("giant_cnt", 32'(giant_cnt_o), 1);
    send_pkt(10'd2, 1200, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({10'd2, 16'd9600});
    idle(2);
    chk_records("max_len");
    chk("max_giant", 32'(giant_cnt_o), 1);

    // Back-to-back A then B (B's sop right after A's eop), gaps inside B
    send_pkt(10'd4, 8, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_pkt(10'd6, 10, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({10'd4, 16'd64});
    exp_q.push_back({10'd6, 16'd80});
    idle(3);
    chk_records("b2b");
    chk("hold_size", 32'(pkt_size_o), 80);
    chk("hold_flow", 32'(rx_flow_num_o), 6);

    // Errored packet: 8 beats with err on eop
    send_pkt(10'd11, 8, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk_records("err");
    chk("err_abort", 32'(abort_cnt_o), 2);

    // Single-beat packets every cycle: 8 bytes each, all runts
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 3'd0, 10'(20 + i), 1'b0);
    idle(2);
    chk_records("single");
    chk("single_runt", 32'(runt_cnt_o), 4);

    // Reset during beat 4 of 8; beats 5..8 arrive as orphans
    send_pkt(10'd12, 3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 10'd12, 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i      = 1'b1;
    st_valid_i = 1'b0;
    send_pkt(10'd12, 4, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk_records("rst_mid");
    chk("rst_mid_abort", 32'(abort_cnt_o), 4);
    chk("rst_mid_runt",  32'(runt_cnt_o), 0);
    chk("rst_mid_giant", 32'(giant_cnt_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
